pipelined_data_memory: RTL and testbench

- Block-granular data memory that accepts up to QUEUE_DEPTH outstanding requests instead of one.
- Supports per-byte write enables and read-response backpressure.
- Each request completes a fixed DELAY cycles after acceptance, strictly in order.
- Sits below the data cache as its refill/writeback target; drop-in successor to the single-outstanding data memory model.

---
 rtl/pipelined_data_memory.sv | 155 +++++++++++++++
 tb/tb_pipelined_data_memory.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_data_memory.sv
// Block-granular data memory with an in-order queue of up to QUEUE_DEPTH outstanding
// requests, each completing DELAY cycles after acceptance. Optional macro: DMEM_PERF_COUNTERS_EN.
module pipelined_data_memory #(
  parameter int MEM_DEPTH   = 16384,
  parameter int DELAY       = 50,
  parameter int BLOCK_SIZE  = 16,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      is_input_valid,
  input  logic [31:0]               addr,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [BLOCK_SIZE*8-1:0]   din,
  input  logic [BLOCK_SIZE-1:0]     byte_en,
  output logic                      mem_ready,
  output logic                      is_output_valid,
  output logic [BLOCK_SIZE*8-1:0]   dout,
  input  logic                      resp_ready
`ifdef DMEM_PERF_COUNTERS_EN
  ,
  output logic [31:0]               stat_reads,
  output logic [31:0]               stat_writes,
  output logic [31:0]               stat_full_stalls
`endif
);

  localparam int DW = BLOCK_SIZE * 8;
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(DELAY + 1);

  typedef struct packed {
    logic [AW-1:0]         addr;
    logic                  is_write;
    logic [DW-1:0]         data;
    logic [BLOCK_SIZE-1:0] be;
  } entry_t;

  entry_t          q_entry [QUEUE_DEPTH];
  logic [CW-1:0]   cnt_q   [QUEUE_DEPTH];
  logic [CW-1:0]   cnt_d   [QUEUE_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q,  count_d;

  logic [DW-1:0]   mem [MEM_DEPTH];

  logic            req;
  logic            push;
  logic            pop;
  logic            head_done;
  logic            head_commit;
  logic            head_read;
  entry_t          head;
  logic [DW-1:0]   head_word;
  logic [DW-1:0]   merged_word;
  logic            unused_addr_hi;

  // Block index bits above the memory depth are ignored by design.
  assign unused_addr_hi = ^addr[31:AW];

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    req         = is_input_valid & (mem_read | mem_write);
    mem_ready   = (count_q < (PW+1)'(QUEUE_DEPTH));
    push        = req & mem_ready;
    head        = q_entry[rd_ptr_q];
    head_done   = (count_q != '0) && (cnt_q[rd_ptr_q] == '0);
    head_commit = head_done & head.is_write;
    head_read   = head_done & ~head.is_write;
    pop         = head_commit | (head_read & resp_ready);

    // The head reads memory at completion, so all older writes have already committed.
    head_word       = mem[head.addr];
    is_output_valid = head_read;
    dout            = head_read ? head_word : '0;

    merged_word = head_word;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (head.be[i]) merged_word[8*i +: 8] = head.data[8*i +: 8];
    end
  end

  // Freed slots always sit at zero (only a zero-countdown head pops), so every
  // nonzero countdown belongs to an occupied entry.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : cnt_q[i];
      if (push && (wr_ptr_q == PW'(i))) cnt_d[i] = CW'(DELAY);
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) cnt_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < QUEUE_DEPTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // NOTE: entry payloads and the memory array carry no reset; validity is held by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      q_entry[wr_ptr_q] <= '{addr:     addr[AW-1:0],
                             is_write: mem_write,
                             data:     din,
                             be:       byte_en};
    end
  end

  always_ff @(posedge clk) begin
    if (head_commit) mem[head.addr] <= merged_word;
  end

`ifdef DMEM_PERF_COUNTERS_EN
  logic [31:0] stat_reads_q, stat_writes_q, stat_full_stalls_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads_q       <= '0;
      stat_writes_q      <= '0;
      stat_full_stalls_q <= '0;
    end else begin
      if (push &  mem_write) stat_writes_q      <= stat_writes_q + 32'd1;
      if (push & ~mem_write) stat_reads_q       <= stat_reads_q + 32'd1;
      if (req & ~mem_ready)  stat_full_stalls_q <= stat_full_stalls_q + 32'd1;
    end
  end

  assign stat_reads       = stat_reads_q;
  assign stat_writes      = stat_writes_q;
  assign stat_full_stalls = stat_full_stalls_q;
`endif

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Randomized and directed bench for pipelined_data_memory against a transaction-level
// reference: a FIFO of pending requests with ready times and a block-array memory image.
module tb_pipelined_data_memory;

  localparam int MEM_DEPTH   = 64;
  localparam int DELAY       = 4;
  localparam int BLOCK_SIZE  = 16;
  localparam int QUEUE_DEPTH = 4;
  localparam int DW          = BLOCK_SIZE * 8;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  is_input_valid;
  logic [31:0]           addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [DW-1:0]         din;
  logic [BLOCK_SIZE-1:0] byte_en;
  logic                  mem_ready;
  logic                  is_output_valid;
  logic [DW-1:0]         dout;
  logic                  resp_ready;
`ifdef DMEM_PERF_COUNTERS_EN
  logic [31:0]           stat_reads, stat_writes, stat_full_stalls;
`endif

  pipelined_data_memory #(
    .MEM_DEPTH(MEM_DEPTH), .DELAY(DELAY), .BLOCK_SIZE(BLOCK_SIZE), .QUEUE_DEPTH(QUEUE_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .is_input_valid(is_input_valid), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din), .byte_en(byte_en),
    .mem_ready(mem_ready), .is_output_valid(is_output_valid), .dout(dout),
    .resp_ready(resp_ready)
`ifdef DMEM_PERF_COUNTERS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_full_stalls(stat_full_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_write;
    int            blk;
    logic [DW-1:0] data;
    logic [15:0]   be;
    int            ready_edge;
  } req_t;

  req_t          pend[$];
  logic [DW-1:0] mem_m [MEM_DEPTH];
  int            edge_no = 0;
  int            m_reads = 0, m_writes = 0, m_stalls = 0;
  int            n_vec = 0, n_miscompare = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit head_visible();
    return (pend.size() > 0) && (pend[0].ready_edge <= edge_no);
  endfunction

  // Applies the edge that just occurred to the reference, using the inputs held across it.
  task automatic model_edge();
    bit   vis, rq;
    int   size0;
    req_t r;
    vis   = head_visible();
    size0 = pend.size();
    rq    = is_input_valid && (mem_read || mem_write);
    edge_no++;
    if (vis && (pend[0].is_write || resp_ready)) begin
      if (pend[0].is_write) begin
        for (int i = 0; i < BLOCK_SIZE; i++)
          if (pend[0].be[i]) mem_m[pend[0].blk][8*i +: 8] = pend[0].data[8*i +: 8];
      end
      void'(pend.pop_front());
    end
    if (rq && size0 < QUEUE_DEPTH) begin
      r.is_write   = mem_write;
      r.blk        = int'(addr % MEM_DEPTH);
      r.data       = din;
      r.be         = byte_en;
      r.ready_edge = edge_no + DELAY;
      pend.push_back(r);
      if (mem_write) m_writes++; else m_reads++;
    end
    if (rq && size0 >= QUEUE_DEPTH) m_stalls++;
  endtask

  task automatic compare_outputs();
    bit exp_v;
    exp_v = head_visible() && !pend[0].is_write;
    check("mem_ready", mem_ready, (pend.size() < QUEUE_DEPTH));
    check("out_valid", is_output_valid, exp_v);
    check("dout", dout, exp_v ? mem_m[pend[0].blk] : '0);
`ifdef DMEM_PERF_COUNTERS_EN
    check("stat_reads", stat_reads, m_reads);
    check("stat_writes", stat_writes, m_writes);
    check("stat_stalls", stat_full_stalls, m_stalls);
`endif
  endtask

  task automatic cycle(input bit v, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [DW-1:0] d, input logic [15:0] be, input bit rr);
    is_input_valid = v;  mem_read = rd; mem_write = wr;
    addr = a; din = d; byte_en = be; resp_ready = rr;
    @(posedge clk);
    #1;
    model_edge();
    compare_outputs();
  endtask

  task automatic idle(input bit rr);
    cycle(0, 0, 0, '0, '0, '0, rr);
  endtask

  task automatic send(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [DW-1:0] d, input logic [15:0] be, input bit rr);
    int n = 0;
    while (!mem_ready && n < 100) begin idle(rr); n++; end
    check("send_ready", mem_ready, 1);
    cycle(1, rd, wr, a, d, be, rr);
  endtask

  task automatic wait_valid(input string tag, input bit rr);
    int n = 0;
    while (!is_output_valid && n < 40) begin idle(rr); n++; end
    check(tag, is_output_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (pend.size() > 0 && n < 200) begin idle(1); n++; end
    check("drain_ready", mem_ready, 1);
  endtask

  // Asserted mid-cycle; outputs must respond before any clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    is_input_valid = 0; mem_read = 0; mem_write = 0; resp_ready = 1;
    pend.delete();
    m_reads = 0; m_writes = 0; m_stalls = 0;
    #1;
    check("rst_ready", mem_ready, 1);
    check("rst_valid", is_output_valid, 0);
    check("rst_dout", dout, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [DW-1:0] held;
  logic [DW-1:0] pat;

  initial begin
    reset_n = 1'b0;
    is_input_valid = 0; mem_read = 0; mem_write = 0;
    addr = '0; din = '0; byte_en = '0; resp_ready = 1;
    for (int i = 0; i < MEM_DEPTH; i++) mem_m[i] = '0;
    #1;
    check("por_ready", mem_ready, 1);
    check("por_valid", is_output_valid, 0);
    check("por_dout", dout, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Give every block a known value before anything reads it.
    for (int i = 0; i < MEM_DEPTH; i++)
      send(0, 1, i, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1);
    drain();

    // Full write then read of the same block: response exactly one cycle, after edge 5.
    pat = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    send(0, 1, 5, pat, 16'hFFFF, 1);
    send(1, 0, 5, '0, '0, 1);
    repeat (3) idle(1);
    check("t1_early", is_output_valid, 0);
    idle(1);
    check("t1_valid", is_output_valid, 1);
    check("t1_dout", dout, pat);
    idle(1);
    check("t1_once", is_output_valid, 0);
    drain();

    // Partial byte-enable write merges over existing bytes.
    send(0, 1, 7, '1, 16'hFFFF, 1);
    send(0, 1, 7, '0, 16'h000F, 1);
    send(1, 0, 7, '0, '0, 1);
    wait_valid("t2_wait", 1);
    check("t2_dout", dout, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);
    idle(1);
    drain();

    // Four back-to-back reads fill the queue and return on consecutive cycles.
    for (int k = 0; k < 4; k++) send(1, 0, k, '0, '0, 1);
    check("t3_full", mem_ready, 0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check("t3_valid", is_output_valid, 1);
      check("t3_dout", dout, mem_m[k]);
      if (k == 1) check("t3_ready_again", mem_ready, 1);
    end
    idle(1);
    check("t3_done", is_output_valid, 0);
    drain();

    // Backpressure holds the head and keeps the queue full.
    for (int k = 0; k < 4; k++) send(1, 0, 10 + k, '0, '0, 0);
    wait_valid("t4_wait", 0);
    held = dout;
    check("t4_first", held, mem_m[10]);
    for (int k = 0; k < 10; k++) begin
      idle(0);
      check("t4_hold", dout, held);
      check("t4_hold_v", is_output_valid, 1);
      check("t4_full", mem_ready, 0);
    end
    for (int k = 0; k < 4; k++) begin
      check("t4_order_v", is_output_valid, 1);
      check("t4_order", dout, mem_m[10 + k]);
      idle(1);
    end
    check("t4_done", is_output_valid, 0);
    drain();

    // Reset discards an uncommitted write; memory keeps the committed one.
    send(0, 1, 9, 128'h1, 16'hFFFF, 1);
    drain();
    send(0, 1, 9, 128'h2, 16'hFFFF, 1);
    repeat (2) idle(1);
    do_reset();
    send(1, 0, 9, '0, '0, 1);
    wait_valid("t5_wait", 1);
    check("t5_dout", dout, 128'h1);
    idle(1);
    drain();

    // Read+write together acts as a write with no response.
    do_reset();
    send(1, 1, 2, 128'h3, 16'hFFFF, 1);
    repeat (DELAY + 2) begin
      idle(1);
      check("t6_noresp", is_output_valid, 0);
    end
    send(1, 0, 2, '0, '0, 1);
    wait_valid("t6_wait", 1);
    check("t6_dout", dout, 128'h3);
`ifdef DMEM_PERF_COUNTERS_EN
    check("t6_stat_w", stat_writes, 32'd1);
    check("t6_stat_r", stat_reads, 32'd1);
`endif
    idle(1);
    drain();

    // Random traffic with random backpressure and ignored upper address bits.
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
            $urandom_range(0, 3) != 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
